// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for the 8-bit ALU: collects command/operand bytes, issues them
// to the ALU from registers and holds the captured result on a valid/ready port.
module alu_op_sequencer #(
  parameter int unsigned WIDTH           = 8,
  parameter bit          SKIP_B_ON_SHIFT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             alu_carry,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_negative,
  output logic             out_carry,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       op_count
);

  localparam int unsigned ACC_BIT = 7;
  localparam int unsigned SEL_W   = 3;

  typedef enum logic [2:0] {
    S_CMD   = 3'd0,
    S_GET_A = 3'd1,
    S_GET_B = 3'd2,
    S_EXEC  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             in_fire;
  logic             out_fire;

  // Shift opcodes carry only one operand when the skip option is enabled.
  function automatic logic skip_b(input logic [SEL_W-1:0] sel);
    return SKIP_B_ON_SHIFT && ((sel == 3'b011) || (sel == 3'b100));
  endfunction

  assign in_ready = !rst && ((state == S_CMD) || (state == S_GET_A) || (state == S_GET_B));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_CMD;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= '0;
      acc          <= '0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_negative <= 1'b0;
      out_carry    <= 1'b0;
      out_err      <= 1'b0;
      out_valid    <= 1'b0;
      op_count     <= '0;
    end else begin
      case (state)
        S_CMD: begin
          if (in_fire) begin
            alu_sel <= in_data[SEL_W-1:0];
            if (in_data[ACC_BIT]) begin
              alu_a <= acc;
              if (skip_b(in_data[SEL_W-1:0])) begin
                alu_b <= '0;
                state <= S_EXEC;
              end else begin
                state <= S_GET_B;
              end
            end else begin
              state <= S_GET_A;
            end
          end
        end
        S_GET_A: begin
          if (in_fire) begin
            alu_a <= in_data;
            if (skip_b(alu_sel)) begin
              alu_b <= '0;
              state <= S_EXEC;
            end else begin
              state <= S_GET_B;
            end
          end
        end
        S_GET_B: begin
          if (in_fire) begin
            alu_b <= in_data;
            state <= S_EXEC;
          end
        end
        // ALU inputs have been stable for a full cycle; capture its outputs.
        S_EXEC: begin
          out_result   <= alu_result;
          out_zero     <= alu_zero;
          out_negative <= alu_negative;
          out_carry    <= alu_carry;
          out_err      <= (alu_sel >= 3'b101);
          out_valid    <= 1'b1;
          state        <= S_OUT;
        end
        S_OUT: begin
          if (out_fire) begin
            out_valid <= 1'b0;
            acc       <= out_result;
            op_count  <= op_count + 8'(1);
            state     <= S_CMD;
          end
        end
        default: state <= S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU on its A/B/SEL outputs.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_zero, alu_negative, alu_carry;
  logic [7:0] out_result;
  logic       out_zero, out_negative, out_carry, out_err, out_valid;
  logic       out_ready;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(8), .SKIP_B_ON_SHIFT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_negative(alu_negative), .alu_carry(alu_carry),
    .out_result(out_result), .out_zero(out_zero), .out_negative(out_negative),
    .out_carry(out_carry), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .op_count(op_count)
  );

  // ALU: add, sub, or, shl, shr; illegal codes return a^b.
  always_comb begin
    logic [8:0] t;
    t = 9'd0;
    case (alu_sel)
      3'b000: t = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: t = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010: t = {1'b0, alu_a | alu_b};
      3'b011: t = {1'b0, alu_a[6:0], 1'b0};
      3'b100: t = {2'b00, alu_a[7:1]};
      default: t = {1'b0, alu_a ^ alu_b};
    endcase
    alu_result   = t[7:0];
    alu_carry    = t[8];
    alu_zero     = (t[7:0] == 8'd0);
    alu_negative = t[7];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a byte and return #1 after the edge that transfers it.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 16'd0, 16'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("out_timeout", 16'd0, 16'd1);
  endtask

  task automatic check_out(input string tag, input logic [7:0] res,
                           input logic z, input logic c, input logic e);
    wait_out();
    check({tag, "_res"}, 16'(out_result), 16'(res));
    check({tag, "_zero"}, 16'(out_zero), 16'(z));
    check({tag, "_neg"}, 16'(out_negative), 16'(res[7]));
    check({tag, "_carry"}, 16'(out_carry), 16'(c));
    check({tag, "_err"}, 16'(out_err), 16'(e));
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    check({tag, "_vld_drop"}, 16'(out_valid), 16'd0);
    check({tag, "_count"}, 16'(op_count), 16'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1; in_data = 8'd0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("rst_in_ready_low", 16'(in_ready), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_alu_a", 16'(alu_a), 16'd0);
    check("rst_alu_b", 16'(alu_b), 16'd0);
    check("rst_alu_sel", 16'(alu_sel), 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_result", 16'(out_result), 16'd0);
    check("rst_count", 16'(op_count), 16'd0);

    // 1: add with latency check, consumer already ready
    send(8'h00); send(8'h03);
    @(negedge clk); out_ready = 1'b1;
    send(8'h02);
    check("t1_exec_vld", 16'(out_valid), 16'd0);
    check("t1_exec_in_ready", 16'(in_ready), 16'd0);
    @(posedge clk); #1;
    check("t1_vld_k2", 16'(out_valid), 16'd1);
    check("t1_res", 16'(out_result), 16'h05);
    check("t1_zero", 16'(out_zero), 16'd0);
    check("t1_carry", 16'(out_carry), 16'd0);
    check("t1_err", 16'(out_err), 16'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt = 8'd1;
    check("t1_vld_drop", 16'(out_valid), 16'd0);
    check("t1_count", 16'(op_count), 16'd1);
    check("t1_in_ready_back", 16'(in_ready), 16'd1);

    // 2: carry/zero, then accumulator chaining
    send(8'h00); send(8'hFF); send(8'h01);
    check_out("t2a", 8'h00, 1'b1, 1'b1, 1'b0);
    consume("t2a");
    send(8'h82);
    check("t2b_alu_a", 16'(alu_a), 16'h00);
    check("t2b_alu_sel", 16'(alu_sel), 16'd2);
    send(8'h0C);
    check_out("t2b", 8'h0C, 1'b0, 1'b0, 1'b0);
    consume("t2b");
    send(8'h80);
    check("t2c_alu_a", 16'(alu_a), 16'h0C);
    send(8'h01);
    check_out("t2c", 8'h0D, 1'b0, 1'b0, 1'b0);
    consume("t2c");

    // 3: shift opcodes skip the B byte and clear alu_b
    send(8'h03); send(8'h81);
    check("t3_in_ready_drop", 16'(in_ready), 16'd0);
    check("t3_alu_b", 16'(alu_b), 16'h00);
    check_out("t3a", 8'h02, 1'b0, 1'b0, 1'b0);
    consume("t3a");
    send(8'h04); send(8'h81);
    check("t3b_in_ready_drop", 16'(in_ready), 16'd0);
    check_out("t3b", 8'h40, 1'b0, 1'b0, 1'b0);
    consume("t3b");

    // 4: backpressure with ignored input pulses
    send(8'h00); send(8'h10); send(8'h20);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_data  = 8'hAA;
      in_valid = 1'(i % 2);
      check("t4_hold_res", 16'(out_result), 16'h30);
      check("t4_hold_vld", 16'(out_valid), 16'd1);
      check("t4_in_ready", 16'(in_ready), 16'd0);
    end
    @(negedge clk); in_valid = 1'b0;
    consume("t4");
    check("t4_state_cmd", 16'(in_ready), 16'd1);

    // 5: reset in the middle of an accumulator op
    send(8'h81);
    @(negedge clk); rst = 1'b1;
    #1 check("t5_in_ready_rst", 16'(in_ready), 16'd0);
    @(posedge clk); #1 rst = 1'b0;
    exp_cnt = 8'd0;
    #1;
    check("t5_in_ready", 16'(in_ready), 16'd1);
    check("t5_count", 16'(op_count), 16'd0);
    check("t5_out_valid", 16'(out_valid), 16'd0);
    send(8'h80);
    check("t5_acc_cleared", 16'(alu_a), 16'h00);
    send(8'h05);
    check_out("t5a", 8'h05, 1'b0, 1'b0, 1'b0);
    consume("t5a");
    send(8'h00); send(8'h01); send(8'h01);
    check_out("t5b", 8'h02, 1'b0, 1'b0, 1'b0);
    consume("t5b");

    // 6: illegal opcode passthrough, then op_count wrap
    send(8'h07); send(8'h05); send(8'h05);
    check_out("t6", 8'h00, 1'b1, 1'b0, 1'b1);
    consume("t6");
    for (int i = 0; i < 256; i++) begin
      send(8'h83);
      wait_out();
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
      if (exp_cnt == 8'd0) check("t6_wrap_zero", 16'(op_count), 16'd0);
    end
    check("t6_wrap_final", 16'(op_count), 16'(exp_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
